pueo_beam_thresh_array: RTL and testbench
=========================================

# pueo_beam_thresh_array

Parametrised multi-beam threshold trigger for the PUEO beamformer. It takes NBEAMS beams, each delivered as two IN_WIDTH-bit unsigned samples per clock. For each beam it forms the windowed sum of the last WINDOW per-clock sums and compares it against a per-beam double-buffered threshold. Triggers pass through a per-beam mask and a retrigger holdoff before driving one trigger bit per beam to the trigger-combining logic downstream.

## Interface
- NBEAMS, 2: number of beams; ≥1.
- IN_WIDTH, 17: unsigned width of each beam sample input.
- WINDOW, 2: number of consecutive per-clock sums added together (FIR length); ≥1.
- THRESH_WIDTH, 18: unsigned threshold width; ≤ SUM_WIDTH.
- HOLDOFF, 0: cycles a beam is suppressed after it triggers; 0 = no suppression.
- Derived: SUM_WIDTH = IN_WIDTH+1+$clog2(WINDOW); ADDR_WIDTH = max(1,$clog2(NBEAMS)).

Ports:
- clk_i  in  1  sole clock.
- aresetn_i  in  1  asynchronous, active-low reset.
- beam_in0_i  in  NBEAMS*IN_WIDTH  first sample per beam; beam b at [b*IN_WIDTH +: IN_WIDTH].
- beam_in1_i  in  NBEAMS*IN_WIDTH  second sample per beam, same packing.
- thresh_i  in  THRESH_WIDTH  threshold write data.
- thresh_addr_i  in  ADDR_WIDTH  beam index for the write.
- thresh_wr_i  in  1  writes thresh_i into the shadow register of the addressed beam.
- update_i  in  1  copies all shadow thresholds to the active thresholds.
- beam_mask_i  in  NBEAMS  1 = beam disabled.
- trigger_o  out  NBEAMS  per-beam trigger, one-cycle pulse per trigger event.

## Operation
- Stage R1: T_b = in0_b + in1_b, width IN_WIDTH+1, no overflow.
- Stage R2: S_b = sum of the last WINDOW T_b values.
  - Implemented as a running sum, S <= S + T_new − T_(WINDOW-old), using a WINDOW-deep delay line.
  - WINDOW=1 degenerates to S = T.
  - Full precision at SUM_WIDTH; no saturation is needed.
- Stage R3: hit_b = (S_b > active_thresh_b). The compare is strict. The threshold is zero-extended to SUM_WIDTH.
- Stage R4 output logic, per beam:
  - trigger_o[b] = hit_b & ~beam_mask_i[b] & (holdoff_cnt_b == 0). beam_mask_i is sampled at R4.
  - On a trigger, holdoff_cnt_b loads HOLDOFF. Otherwise it decrements while nonzero.
  - Masked hits do not load the counter.
- Thresholds:
  - thresh_wr_i with thresh_addr_i ≥ NBEAMS is ignored.
  - update_i loads active from the shadow value held before the edge. A same-cycle write lands in the shadow only and takes effect on the next update_i.
  - The new active threshold applies to the R3 compare from the cycle after the update edge.
- Reset (asynchronous assert, synchronous-to-clock deassert is assumed by the system):
  - Clears R1/R2/R3, the delay lines, running sums, holdoff counters and trigger_o (all 0).
  - Sets shadow and active thresholds to all-ones, so no beam triggers until a threshold is loaded and updated.
  - A mid-operation reset restarts the window from zero history.
- No state machine beyond per-beam holdoff counters (IDLE when 0, HOLD when >0).

## Timing
- Latency: samples presented at edge k affect trigger_o after edge k+4 (R1..R4).
- Window history fills over WINDOW cycles after reset. Sums during fill include zeros for the missing history.
- Holdoff: a trigger at cycle t blocks trigger_o[b] at cycles t+1..t+HOLDOFF. The earliest retrigger is at t+HOLDOFF+1.
- Throughput: one sample pair per beam per clock; no stalls, no backpressure.
- All outputs are registered. No combinational path from inputs to trigger_o.

## Structure
- Package pueo_beam_thresh_pkg holds:
  - the sum_width(IN_WIDTH, WINDOW) function;
  - the default parameter constants;
  - the all-ones threshold reset constant.
- Sub-module pueo_beam_window_sum, one instance per beam: R1 add, R2 delay line and running sum, R3 compare against the supplied active threshold, output hit.
- The top level holds the threshold shadow/active banks, the mask and holdoff (R4), and the generate loop.
- No DSP48E2 instantiation is required. Inference into DSP SIMD lanes is permitted provided latency is unchanged.

## Test plan
- **Reset default:** hold aresetn_i low, then release, drive 0x1FFFF on all inputs → trigger_o stays 0 (thresholds all-ones).
- **Exclusive threshold (defaults):** write beam0 thresh=80000, pulse update_i, drive in0=in1=20000 steady → no trigger. One cycle of in0=20001 → trigger_o[0] pulses exactly 4 cycles later. It then pulses once more on the following cycle, because the window still contains 40001.
- **Shadow semantics:** write 1000 to beam1 with no update → beam1 stays silent at S=80000. Same-cycle write 500 + update → active=1000 and triggers. A later update → active=500.
- **Holdoff (HOLDOFF=3):** continuous over-threshold input → trigger_o[b] pulses every 4th cycle. Setting beam_mask_i[b]=1 → no pulses and no counter load.
- **WINDOW=4, NBEAMS=4:** impulse T=1000 on beam2 with thresh=999 → exactly 4 consecutive hit cycles (before holdoff). Other beams stay 0. A write with address ≥ NBEAMS is ignored.
- **Reset mid-stream:** assert aresetn_i while a window is nonzero → trigger_o=0 immediately. After release with zero inputs, no spurious trigger.

Source files
------------

// File: rtl/pueo_beam_thresh_pkg.sv
// Shared constants and helpers for the PUEO multi-beam threshold trigger.
package pueo_beam_thresh_pkg;

    localparam int NBEAMS_DEF       = 2;
    localparam int IN_WIDTH_DEF     = 17;
    localparam int WINDOW_DEF       = 2;
    localparam int THRESH_WIDTH_DEF = 18;
    localparam int HOLDOFF_DEF      = 0;

    localparam int                       MAX_SUM_WIDTH   = 64;
    localparam logic [MAX_SUM_WIDTH-1:0] THRESH_ALL_ONES = '1;

    function automatic int sum_width(input int in_width, input int window);
        return in_width + 1 + $clog2(window);
    endfunction

endpackage

// File: rtl/pueo_beam_window_sum.sv
// One beam: pair add (R1), running windowed sum (R2), strict threshold compare (R3).
module pueo_beam_window_sum
    import pueo_beam_thresh_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int SUM_WIDTH = sum_width(IN_WIDTH, WINDOW)
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic [IN_WIDTH-1:0]  in0_i,
    input  logic [IN_WIDTH-1:0]  in1_i,
    input  logic [SUM_WIDTH-1:0] thresh_i,
    output logic                 hit_o
);
    localparam int TW = IN_WIDTH + 1;

    logic [TW-1:0]        t_q, t_d;
    logic [TW-1:0]        dly_q [WINDOW];
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 hit_q, hit_d;

    // dly_q[WINDOW-1] is the sample leaving the window as t_q enters it.
    always_comb begin
        t_d   = TW'(in0_i) + TW'(in1_i);
        sum_d = sum_q + SUM_WIDTH'(t_q) - SUM_WIDTH'(dly_q[WINDOW-1]);
        hit_d = (sum_q > thresh_i);
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            t_q   <= '0;
            sum_q <= '0;
            hit_q <= 1'b0;
            for (int i = 0; i < WINDOW; i++) dly_q[i] <= '0;
        end else begin
            t_q      <= t_d;
            sum_q    <= sum_d;
            hit_q    <= hit_d;
            dly_q[0] <= t_q;
            for (int i = 1; i < WINDOW; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/pueo_beam_thresh_array.sv
// Multi-beam threshold trigger: per-beam window sums, double-buffered thresholds,
// mask and retrigger holdoff.
//   holdoff state | meaning
//   IDLE (cnt==0) | beam may fire on its next hit
//   HOLD (cnt>0)  | beam suppressed, counting down
module pueo_beam_thresh_array
    import pueo_beam_thresh_pkg::*;
#(
    parameter  int NBEAMS       = NBEAMS_DEF,
    parameter  int IN_WIDTH     = IN_WIDTH_DEF,
    parameter  int WINDOW       = WINDOW_DEF,
    parameter  int THRESH_WIDTH = THRESH_WIDTH_DEF,
    parameter  int HOLDOFF      = HOLDOFF_DEF,
    localparam int SUM_WIDTH    = sum_width(IN_WIDTH, WINDOW),
    localparam int ADDR_WIDTH   = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                       clk_i,
    input  logic                       aresetn_i,
    input  logic [NBEAMS*IN_WIDTH-1:0] beam_in0_i,
    input  logic [NBEAMS*IN_WIDTH-1:0] beam_in1_i,
    input  logic [THRESH_WIDTH-1:0]    thresh_i,
    input  logic [ADDR_WIDTH-1:0]      thresh_addr_i,
    input  logic                       thresh_wr_i,
    input  logic                       update_i,
    input  logic [NBEAMS-1:0]          beam_mask_i,
    output logic [NBEAMS-1:0]          trigger_o
);
    localparam int             HW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLDOFF);
    // Thresholds are held at full sum width so the reset value exceeds any reachable sum.
    localparam logic [SUM_WIDTH-1:0] THRESH_RST = THRESH_ALL_ONES[SUM_WIDTH-1:0];

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        logic [SUM_WIDTH-1:0] shadow_q, active_q;
        logic [HW-1:0]        hold_q, hold_d;
        logic                 trig_q, trig_d;
        logic                 hit;

        pueo_beam_window_sum #(
            .IN_WIDTH  (IN_WIDTH),
            .WINDOW    (WINDOW),
            .SUM_WIDTH (SUM_WIDTH)
        ) u_sum (
            .clk_i     (clk_i),
            .aresetn_i (aresetn_i),
            .in0_i     (beam_in0_i[b*IN_WIDTH +: IN_WIDTH]),
            .in1_i     (beam_in1_i[b*IN_WIDTH +: IN_WIDTH]),
            .thresh_i  (active_q),
            .hit_o     (hit)
        );

        always_comb begin
            trig_d = hit & ~beam_mask_i[b] & (hold_q == '0);
            hold_d = hold_q;
            if (trig_d)
                hold_d = HOLD_LOAD;
            else if (hold_q != '0)
                hold_d = hold_q - HW'(1);
        end

        // Addresses at or beyond NBEAMS match no beam, so such writes fall away.
        always_ff @(posedge clk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                shadow_q <= THRESH_RST;
                active_q <= THRESH_RST;
                hold_q   <= '0;
                trig_q   <= 1'b0;
            end else begin
                if (thresh_wr_i && (thresh_addr_i == ADDR_WIDTH'(b)))
                    shadow_q <= SUM_WIDTH'(thresh_i);
                if (update_i)
                    active_q <= shadow_q;
                hold_q <= hold_d;
                trig_q <= trig_d;
            end
        end

        assign trigger_o[b] = trig_q;
    end

endmodule

// File: tb/tb_pueo_beam_thresh_array.sv
// Scoreboard bench for pueo_beam_thresh_array: three parameterisations, directed vectors.
module tb_pueo_beam_thresh_array;
    localparam int IW = 17;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a: defaults (2 beams, WINDOW=2, HOLDOFF=0)
    logic [2*IW-1:0] a_in0, a_in1;
    logic [17:0]     a_th;
    logic [0:0]      a_addr;
    logic            a_wr, a_upd;
    logic [1:0]      a_mask, a_trig;
    // dut_b: 4 beams, WINDOW=4, HOLDOFF=0
    logic [4*IW-1:0] b_in0, b_in1;
    logic [17:0]     b_th;
    logic [1:0]      b_addr;
    logic            b_wr, b_upd;
    logic [3:0]      b_mask, b_trig;
    // dut_c: 2 beams, WINDOW=2, HOLDOFF=3
    logic [2*IW-1:0] c_in0, c_in1;
    logic [17:0]     c_th;
    logic [0:0]      c_addr;
    logic            c_wr, c_upd;
    logic [1:0]      c_mask, c_trig;

    pueo_beam_thresh_array dut_a (
        .clk_i(clk), .aresetn_i(rst_n), .beam_in0_i(a_in0), .beam_in1_i(a_in1),
        .thresh_i(a_th), .thresh_addr_i(a_addr), .thresh_wr_i(a_wr), .update_i(a_upd),
        .beam_mask_i(a_mask), .trigger_o(a_trig));

    pueo_beam_thresh_array #(.NBEAMS(4), .WINDOW(4)) dut_b (
        .clk_i(clk), .aresetn_i(rst_n), .beam_in0_i(b_in0), .beam_in1_i(b_in1),
        .thresh_i(b_th), .thresh_addr_i(b_addr), .thresh_wr_i(b_wr), .update_i(b_upd),
        .beam_mask_i(b_mask), .trigger_o(b_trig));

    pueo_beam_thresh_array #(.HOLDOFF(3)) dut_c (
        .clk_i(clk), .aresetn_i(rst_n), .beam_in0_i(c_in0), .beam_in1_i(c_in1),
        .thresh_i(c_th), .thresh_addr_i(c_addr), .thresh_wr_i(c_wr), .update_i(c_upd),
        .beam_mask_i(c_mask), .trigger_o(c_trig));

    typedef struct {
        logic [1:0] ea;
        logic [3:0] eb;
        logic [1:0] ec;
        int         step;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_n = 0;

    task automatic cmp(input string name, input int step, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: trigger_o=%b expected %b", name, step, act, exp);
        end
    endtask

    // Monitor: one expected trigger vector per DUT for every issued cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            cmp("trig_a", mon_e.step, {2'b00, a_trig}, {2'b00, mon_e.ea});
            cmp("trig_b", mon_e.step, b_trig, mon_e.eb);
            cmp("trig_c", mon_e.step, {2'b00, c_trig}, {2'b00, mon_e.ec});
        end
    end

    task automatic tick(input logic [1:0] ea, input logic [3:0] eb, input logic [1:0] ec);
        exp_t e;
        e.ea = ea; e.eb = eb; e.ec = ec; e.step = step_n;
        sb_q.push_back(e);
        step_n++;
        @(posedge clk);
        #1;
        a_wr = 1'b0; a_upd = 1'b0;
        b_wr = 1'b0; b_upd = 1'b0;
        c_wr = 1'b0; c_upd = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [1:0] ea, input logic [3:0] eb,
                         input logic [1:0] ec);
        for (int i = 0; i < n; i++) tick(ea, eb, ec);
    endtask

    task automatic zero_inputs();
        a_in0 = '0; a_in1 = '0;
        b_in0 = '0; b_in1 = '0;
        c_in0 = '0; c_in1 = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        a_th = '0; a_addr = '0; a_wr = 1'b0; a_upd = 1'b0; a_mask = '0;
        b_th = '0; b_addr = '0; b_wr = 1'b0; b_upd = 1'b0; b_mask = '0;
        c_th = '0; c_addr = '0; c_wr = 1'b0; c_upd = 1'b0; c_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset thresholds block even full-scale inputs.
        a_in0 = '1; a_in1 = '1; b_in0 = '1; b_in1 = '1; c_in0 = '1; c_in1 = '1;
        ticks(8, 2'b00, 4'b0000, 2'b00);
        zero_inputs();
        ticks(6, 2'b00, 4'b0000, 2'b00);

        // Strict threshold at 80000 on dut_a beam0.
        a_th = 18'd80000; a_addr = 1'b0; a_wr = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        a_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        a_in0[0 +: IW] = 17'd20000; a_in1[0 +: IW] = 17'd20000;
        ticks(8, 2'b00, 4'b0000, 2'b00);
        a_in0[0 +: IW] = 17'd20001;
        tick(2'b00, 4'b0000, 2'b00);
        a_in0[0 +: IW] = 17'd20000;
        ticks(3, 2'b00, 4'b0000, 2'b00);
        ticks(2, 2'b01, 4'b0000, 2'b00);
        ticks(3, 2'b00, 4'b0000, 2'b00);
        zero_inputs();
        ticks(6, 2'b00, 4'b0000, 2'b00);

        // Shadow/active semantics on dut_a beam1.
        a_in0[IW +: IW] = 17'd20000; a_in1[IW +: IW] = 17'd20000;
        a_th = 18'd1000; a_addr = 1'b1; a_wr = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        ticks(7, 2'b00, 4'b0000, 2'b00);
        a_th = 18'd500; a_addr = 1'b1; a_wr = 1'b1; a_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        ticks(2, 2'b00, 4'b0000, 2'b00);
        ticks(3, 2'b10, 4'b0000, 2'b00);
        a_in0[IW +: IW] = 17'd200; a_in1[IW +: IW] = 17'd200;
        ticks(5, 2'b10, 4'b0000, 2'b00);
        ticks(5, 2'b00, 4'b0000, 2'b00);
        a_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        ticks(2, 2'b00, 4'b0000, 2'b00);
        ticks(3, 2'b10, 4'b0000, 2'b00);
        zero_inputs();
        ticks(4, 2'b10, 4'b0000, 2'b00);
        ticks(4, 2'b00, 4'b0000, 2'b00);

        // Holdoff of 3 on dut_c beam0, then masking.
        c_th = 18'd100; c_addr = 1'b0; c_wr = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        c_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        c_in0[0 +: IW] = 17'd1000; c_in1[0 +: IW] = 17'd1000;
        ticks(4, 2'b00, 4'b0000, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick(2'b00, 4'b0000, 2'b01);
            ticks(3, 2'b00, 4'b0000, 2'b00);
        end
        c_mask = 2'b01;
        tick(2'b00, 4'b0000, 2'b01);
        ticks(6, 2'b00, 4'b0000, 2'b00);
        c_mask = 2'b00;
        tick(2'b00, 4'b0000, 2'b00);
        tick(2'b00, 4'b0000, 2'b01);
        ticks(3, 2'b00, 4'b0000, 2'b00);
        tick(2'b00, 4'b0000, 2'b01);
        zero_inputs();
        ticks(3, 2'b00, 4'b0000, 2'b00);
        tick(2'b00, 4'b0000, 2'b01);
        ticks(5, 2'b00, 4'b0000, 2'b00);

        // WINDOW=4 impulse on dut_b beam2, then the equal-to-threshold boundary.
        b_th = 18'd999; b_addr = 2'd2; b_wr = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        b_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        b_in0[2*IW +: IW] = 17'd500; b_in1[2*IW +: IW] = 17'd500;
        tick(2'b00, 4'b0000, 2'b00);
        zero_inputs();
        ticks(3, 2'b00, 4'b0000, 2'b00);
        ticks(4, 2'b00, 4'b0100, 2'b00);
        ticks(2, 2'b00, 4'b0000, 2'b00);
        b_in0[2*IW +: IW] = 17'd500; b_in1[2*IW +: IW] = 17'd499;
        tick(2'b00, 4'b0000, 2'b00);
        zero_inputs();
        ticks(8, 2'b00, 4'b0000, 2'b00);

        // Reset mid-stream while dut_b beam2 is firing.
        b_in0[2*IW +: IW] = 17'd500; b_in1[2*IW +: IW] = 17'd500;
        ticks(4, 2'b00, 4'b0000, 2'b00);
        ticks(3, 2'b00, 4'b0100, 2'b00);
        cmp("pre_reset_b", step_n, b_trig, 4'b0100);
        rst_n = 1'b0;
        #1;
        cmp("async_reset_a", step_n, {2'b00, a_trig}, 4'b0000);
        cmp("async_reset_b", step_n, b_trig, 4'b0000);
        cmp("async_reset_c", step_n, {2'b00, c_trig}, 4'b0000);
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_th = 18'd0; b_addr = 2'd2; b_wr = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        b_upd = 1'b1;
        tick(2'b00, 4'b0000, 2'b00);
        ticks(10, 2'b00, 4'b0000, 2'b00);

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
